cipher_sched: RTL and testbench
===============================

CIPHER_SCHED -- requirements
Module: cipher_sched

Interface
REQ-001 Parameter N, default 8, data width of the cipher byte path.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles waited in WAIT for core_v.
REQ-003 clock  input  1  single clock, all flops on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  requester 0/1 wants one byte processed.
REQ-006 din0, din1  input  N each  requester plaintext or ciphertext byte.
REQ-007 shift0, shift1  input  5 each  requester shift amount, 0..31.
REQ-008 dir0, dir1  input  2 each  requester direction: 00 pass, 10 encrypt, 01 decrypt, 11 illegal.
REQ-009 ack0, ack1  output  1 each  one-cycle pulse: request accepted, payload captured.
REQ-010 core_en, core_din, core_shift, core_dir  output  1/N/5/2  command to the shared cipher core.
REQ-011 core_v, core_dout  input  1/N  core result valid and result byte.
REQ-012 rsp_v  output  1  one-cycle response pulse.
REQ-013 rsp_id, rsp_data, rsp_err  output  1/N/1  response owner, result byte, error flag.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP, encoded in registered state.
REQ-016 IDLE: if any req high, grant one, pulse its ack, register din/shift/dir and grant id in the same cycle; else stay.
REQ-017 Arbitration round-robin: single req wins; both high -> grant the requester not granted last; pointer after reset favours req0.
REQ-018 Requester holds req and payload stable until its ack; req still high in the cycle after ack is a new request.
REQ-019 Registered shift normalised mod 26: values 26..31 map to 0..5; 0..25 unchanged.
REQ-020 Granted dir = 11: no core command issued; IDLE -> RESP with rsp_err=1, rsp_data=0.
REQ-021 Otherwise IDLE -> ISSUE; ISSUE drives core_en=1 for exactly one cycle with the registered payload, then -> WAIT.
REQ-022 core_din/core_shift/core_dir hold the registered payload from ISSUE through WAIT; core_en=0 outside ISSUE.
REQ-023 WAIT: core_v=1 captures core_dout, -> RESP with rsp_err=0; core_v in any other state is ignored.
REQ-024 RESP: rsp_v=1 for one cycle with rsp_id/rsp_data/rsp_err, then -> IDLE; no ack issued in RESP.
REQ-025 Minimum latency req -> rsp_v: ack at cycle 0, core_en at cycle 1, rsp_v one cycle after core_v.
REQ-026 rsp_id/rsp_data/rsp_err hold their last values between rsp_v pulses.

Reset
REQ-027 rst low asynchronously forces IDLE, arbitration pointer to favour req0, timeout counter to 0.
REQ-028 During and after reset, all outputs are 0 until the first grant; an in-flight request is dropped without response.

Configuration
REQ-029 Macro CIPHER_SCHED_TIMEOUT_EN: defined -> WAIT counter increments each cycle; after TIMEOUT cycles without core_v -> RESP with rsp_err=1, rsp_data=0; counter cleared on leaving WAIT.
REQ-030 CIPHER_SCHED_TIMEOUT_EN undefined -> no counter logic; WAIT exits only on core_v or reset.

Verification
REQ-031 req0, din0=8'h0b, shift0=5, dir0=10; core_v with 8'h10 three cycles after core_en -> ack0 cycle 0, core_en cycle 1 with core_shift=5, rsp_v cycle 5, rsp_id=0, rsp_data=8'h10, rsp_err=0.
REQ-032 req0 and req1 high together after reset -> ack0 first, rsp_id=0; then ack1, rsp_id=1; repeated simultaneous reqs alternate 0,1,0,1.
REQ-033 shift0=26 then shift0=31 -> core_shift=0 then core_shift=5.
REQ-034 dir1=11 -> ack1, no core_en pulse, rsp_v one cycle later with rsp_id=1, rsp_err=1, rsp_data=0.
REQ-035 With CIPHER_SCHED_TIMEOUT_EN, core_v never asserted -> rsp_err=1 exactly TIMEOUT=16 cycles after entering WAIT; without the macro, busy stays high indefinitely.
REQ-036 rst low while in WAIT -> busy=0, core_en=0 immediately; late core_v produces no rsp_v; next req0 served normally.

Source files
------------

// File: rtl/cipher_sched.sv
// rtl/cipher_sched.sv - two-requester round-robin scheduler for a shared cipher core
// Optional WAIT watchdog enabled by defining CIPHER_SCHED_TIMEOUT_EN.
module cipher_sched #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] din0,
  input  logic [N-1:0] din1,
  input  logic [4:0]   shift0,
  input  logic [4:0]   shift1,
  input  logic [1:0]   dir0,
  input  logic [1:0]   dir1,
  output logic         ack0,
  output logic         ack1,
  output logic         core_en,
  output logic [N-1:0] core_din,
  output logic [4:0]   core_shift,
  output logic [1:0]   core_dir,
  input  logic         core_v,
  input  logic [N-1:0] core_dout,
  output logic         rsp_v,
  output logic         rsp_id,
  output logic [N-1:0] rsp_data,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t       state;
  logic         last_gnt;
  logic         owner;
  logic         any_req;
  logic         gnt_id;
  logic         grant;
  logic [N-1:0] sel_din;
  logic [4:0]   sel_shift;
  logic [1:0]   sel_dir;

`ifdef CIPHER_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`endif

  function automatic logic [4:0] norm_shift(input logic [4:0] s);
    return (s >= 5'd26) ? s - 5'd26 : s;
  endfunction

  // last_gnt resets to 1 so a simultaneous first request goes to req0
  always_comb begin
    any_req   = req0 | req1;
    gnt_id    = (req0 & req1) ? ~last_gnt : req1;
    grant     = rst & (state == IDLE) & any_req;
    ack0      = grant & ~gnt_id;
    ack1      = grant & gnt_id;
    sel_din   = gnt_id ? din1 : din0;
    sel_shift = norm_shift(gnt_id ? shift1 : shift0);
    sel_dir   = gnt_id ? dir1 : dir0;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      owner      <= 1'b0;
      core_en    <= 1'b0;
      core_din   <= '0;
      core_shift <= '0;
      core_dir   <= '0;
      rsp_v      <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
`ifdef CIPHER_SCHED_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rsp_v <= 1'b0;
          if (grant) begin
            last_gnt   <= gnt_id;
            owner      <= gnt_id;
            core_din   <= sel_din;
            core_shift <= sel_shift;
            core_dir   <= sel_dir;
            if (sel_dir == 2'b11) begin
              state    <= RESP;
              rsp_v    <= 1'b1;
              rsp_id   <= gnt_id;
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end else begin
              state   <= ISSUE;
              core_en <= 1'b1;
            end
          end
        end
        ISSUE: begin
          core_en <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (core_v) begin
            state    <= RESP;
            rsp_v    <= 1'b1;
            rsp_id   <= owner;
            rsp_data <= core_dout;
            rsp_err  <= 1'b0;
`ifdef CIPHER_SCHED_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state    <= RESP;
            rsp_v    <= 1'b1;
            rsp_id   <= owner;
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          rsp_v <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_sched.sv
// tb/tb_cipher_sched.sv - self-checking bench for cipher_sched
// Build with CIPHER_SCHED_TIMEOUT_EN defined to exercise the WAIT watchdog.
module tb_cipher_sched;

  logic       clock = 1'b0;
  logic       rst;
  logic       ack0, ack1, core_en, rsp_v, rsp_id, rsp_err, busy;
  logic [7:0] core_din, rsp_data, core_dout;
  logic [4:0] core_shift;
  logic [1:0] core_dir;
  logic       core_v;

  bit         pend[2];
  logic [7:0] p_din[2];
  logic [4:0] p_sh[2];
  logic [1:0] p_dir[2];
  int         last_g;
  int         prev_id;
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  cipher_sched #(.N(8), .TIMEOUT(16)) dut (
    .clock(clock), .rst(rst),
    .req0(pend[0]), .req1(pend[1]),
    .din0(p_din[0]), .din1(p_din[1]),
    .shift0(p_sh[0]), .shift1(p_sh[1]),
    .dir0(p_dir[0]), .dir1(p_dir[1]),
    .ack0(ack0), .ack1(ack1),
    .core_en(core_en), .core_din(core_din), .core_shift(core_shift), .core_dir(core_dir),
    .core_v(core_v), .core_dout(core_dout),
    .rsp_v(rsp_v), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference cipher: Caesar-style add/subtract of the shift, modulo 256
  function automatic logic [7:0] model_out(input logic [7:0] d, input logic [4:0] s,
                                           input logic [1:0] r);
    case (r)
      2'b10:   return 8'(d + 8'(s));
      2'b01:   return 8'(d - 8'(s));
      default: return d;
    endcase
  endfunction

  // Enter in an IDLE cycle just after the rising edge with requests driven; leave one edge after RESP.
  task automatic serve_one(input int dly, input bit noise);
    int         g;
    logic [7:0] d, o;
    logic [4:0] s;
    logic [1:0] r;
    g = (pend[0] && pend[1]) ? 1 - last_g : (pend[1] ? 1 : 0);
    @(negedge clock);
    chk("ack0", ack0, g == 0);
    chk("ack1", ack1, g == 1);
    chk("busy_idle", busy, 0);
    chk("rsp_id_hold", rsp_id, prev_id);
    chk("rsp_v_idle", rsp_v, 0);
    d = p_din[g];
    s = 5'(p_sh[g] % 26);
    r = p_dir[g];
    o = model_out(d, s, r);
    @(posedge clock); #1;
    pend[g] = 1'b0;
    last_g  = g;
    if (noise) begin
      core_v    = 1'b1;
      core_dout = ~o;
    end
    @(negedge clock);
    if (r == 2'b11) begin
      chk("err_rsp_v", rsp_v, 1);
      chk("err_rsp_id", rsp_id, g);
      chk("err_rsp_err", rsp_err, 1);
      chk("err_rsp_data", rsp_data, 0);
      chk("err_core_en", core_en, 0);
    end else begin
      chk("core_en", core_en, 1);
      chk("core_din", core_din, d);
      chk("core_shift", core_shift, s);
      chk("core_dir", core_dir, r);
      chk("busy_issue", busy, 1);
      chk("no_ack_busy", {ack0, ack1}, 0);
      @(posedge clock); #1;
      core_v = 1'b0;
      for (int i = 1; i < dly; i++) begin
        @(negedge clock);
        chk("core_en_wait", core_en, 0);
        chk("rsp_v_wait", rsp_v, 0);
        chk("core_shift_hold", core_shift, s);
        @(posedge clock); #1;
      end
      core_v    = 1'b1;
      core_dout = o;
      @(negedge clock);
      chk("rsp_v_early", rsp_v, 0);
      @(posedge clock); #1;
      core_v    = 1'b0;
      core_dout = 8'($urandom);
      @(negedge clock);
      chk("rsp_v", rsp_v, 1);
      chk("rsp_id", rsp_id, g);
      chk("rsp_data", rsp_data, o);
      chk("rsp_err", rsp_err, 0);
      chk("no_ack_resp", {ack0, ack1}, 0);
    end
    prev_id = g;
    @(posedge clock); #1;
  endtask

  task automatic load(input int who, input logic [7:0] d, input logic [4:0] s, input logic [1:0] r);
    pend[who]  = 1'b1;
    p_din[who] = d;
    p_sh[who]  = s;
    p_dir[who] = r;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; core_v = 1'b0; core_dout = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; p_din[i] = '0; p_sh[i] = '0; p_dir[i] = '0;
    end
    last_g = 1; prev_id = 0;
    repeat (2) @(posedge clock);
    #1;
    load(0, 8'h55, 5'd3, 2'b10);
    load(1, 8'haa, 5'd4, 2'b01);
    @(negedge clock);
    chk("rst_ack", {ack0, ack1}, 0);
    chk("rst_outs", {core_en, rsp_v, rsp_id, rsp_err, busy}, 0);
    chk("rst_core", {core_din, core_shift, core_dir}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(posedge clock); #1;
    rst = 1'b1;

    // simultaneous requests alternate starting with requester 0
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        load(0, 8'($urandom), 5'($urandom), 2'b10);
        load(1, 8'($urandom), 5'($urandom), 2'b01);
      end
      serve_one(2, 0);
      serve_one(1, 0);
    end

    load(0, 8'h0b, 5'd5, 2'b10);
    serve_one(3, 1);
    load(0, 8'h40, 5'd26, 2'b10);
    serve_one(1, 0);
    load(0, 8'h40, 5'd31, 2'b01);
    serve_one(2, 0);
    load(1, 8'h77, 5'd9, 2'b11);
    serve_one(1, 0);

    for (int k = 0; k < 30; k++) begin
      int mask;
      mask = $urandom_range(1, 3);
      if (mask[0]) load(0, 8'($urandom), 5'($urandom), 2'($urandom));
      if (mask[1]) load(1, 8'($urandom), 5'($urandom), 2'($urandom));
      while (pend[0] || pend[1]) serve_one($urandom_range(1, 5), 1'($urandom_range(0, 1)));
    end

    load(0, 8'h21, 5'd2, 2'b10);
    @(negedge clock);
    chk("stall_ack0", ack0, 1);
    @(posedge clock); #1;
    pend[0] = 1'b0;
    last_g  = 0;
`ifdef CIPHER_SCHED_TIMEOUT_EN
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      chk("tmo_rsp_v", rsp_v, c == 18);
      if (c == 18) begin
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_data", rsp_data, 0);
        chk("tmo_rsp_id", rsp_id, 0);
      end
      @(posedge clock); #1;
    end
    load(0, 8'h33, 5'd1, 2'b10);
    @(posedge clock); #1;
    pend[0] = 1'b0;
    @(posedge clock); #1;
`else
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (c == 1 || c == 60) begin
        chk("stall_busy", busy, 1);
        chk("stall_rsp_v", rsp_v, 0);
      end
      @(posedge clock); #1;
    end
`endif
    // asynchronous reset while waiting on the core
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_core_en", core_en, 0);
    chk("arst_rsp_v", rsp_v, 0);
    @(posedge clock); #1;
    rst    = 1'b1;
    core_v = 1'b1;
    core_dout = 8'hee;
    @(negedge clock);
    chk("late_core_v", rsp_v, 0);
    chk("late_busy", busy, 0);
    @(posedge clock); #1;
    core_v = 1'b0;
    last_g = 1; prev_id = 0;
    load(0, 8'h90, 5'd7, 2'b01);
    serve_one(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
